// File: rtl/sail_mem_pkg.sv
// Shared definitions for the data-memory path: FSM states, MMIO boundary,
// access size/sign codes and the posted-store entry layout.
package sail_mem_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_ISSUE,
        M_WAIT
    } mem_state_e;

    localparam logic [31:0] MMIO_BASE = 32'h2000;

    // sign_mask = {signed, size_mask[2:0]}; size_mask 001 byte, 011 half, 111 word
    localparam logic [3:0] SM_BYTE  = 4'b1001;
    localparam logic [3:0] SM_BYTEU = 4'b0001;
    localparam logic [3:0] SM_HALF  = 4'b1011;
    localparam logic [3:0] SM_HALFU = 4'b0011;
    localparam logic [3:0] SM_WORD  = 4'b0111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sign_mask;
    } sb_entry_t;

    function automatic logic is_mmio(input logic [31:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular queue of posted stores with a parallel word-address match
// across all valid entries.
module store_fifo
    import sail_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  sb_entry_t               push_entry,
    input  logic                    pop,
    output sb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [29:0]             lookup_word,
    output logic                    hit
);
    localparam int unsigned PW = $clog2(DEPTH);

    sb_entry_t       entries [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: validity comes only from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_entry;
    end

    assign head = entries[rd_ptr];

    // Entry i is valid when its distance from rd_ptr is below count (or the queue is full).
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((PW'(i) - rd_ptr) < count[PW-1:0] || count[PW]) &&
                entries[i].addr[31:2] == lookup_word) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer between the MEM stage and data_mem: queues stores,
// lets non-conflicting loads bypass, and serialises requests to memory.
module store_buffer
    import sail_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    mem_state_e     state;
    mem_state_e     state_next;
    logic           op_load;
    logic           ld_done;
    logic [CW-1:0]  count;
    sb_entry_t      head;
    sb_entry_t      push_entry;
    logic           hit;
    logic           hazard;
    logic           load_pending;
    logic           head_done;
    logic           load_done;
    logic           full;
    logic           push;
    logic           sel_load;
    logic           sel_store;

    assign push_entry = '{addr: cpu_addr, wdata: cpu_wdata, sign_mask: cpu_sign_mask};

    store_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (head_done),
        .head        (head),
        .count       (count),
        .lookup_word (cpu_addr[31:2]),
        .hit         (hit)
    );

    // Device reads stay ordered behind every queued store.
    assign hazard       = hit | (is_mmio(cpu_addr) & (count != '0));
    assign load_pending = cpu_memread & ~ld_done & ~hazard;
    assign head_done    = (state == M_WAIT) & ~mem_stall & ~op_load;
    assign load_done    = (state == M_WAIT) & ~mem_stall & op_load;
    assign full         = (count == CW'(DEPTH));
    assign push         = cpu_memwrite & (~full | head_done);
    assign cpu_stall    = (cpu_memread & ~ld_done) | (cpu_memwrite & full & ~head_done);
    assign mem_memread  = (state == M_ISSUE) & op_load;
    assign mem_memwrite = (state == M_ISSUE) & ~op_load;

    always_comb begin
        state_next = state;
        sel_load   = 1'b0;
        sel_store  = 1'b0;
        unique case (state)
            M_IDLE: begin
                if (load_pending) begin
                    sel_load   = 1'b1;
                    state_next = M_ISSUE;
                end else if (count != '0) begin
                    sel_store  = 1'b1;
                    state_next = M_ISSUE;
                end
            end
            M_ISSUE: state_next = M_WAIT;
            M_WAIT:  if (!mem_stall) state_next = M_IDLE;
            default: state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= M_IDLE;
            op_load       <= 1'b0;
            ld_done       <= 1'b0;
            cpu_rdata     <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_sign_mask <= '0;
        end else begin
            state   <= state_next;
            ld_done <= load_done;
            if (load_done) cpu_rdata <= mem_rdata;
            if (sel_load) begin
                mem_addr      <= cpu_addr;
                mem_sign_mask <= cpu_sign_mask;
                op_load       <= 1'b1;
            end else if (sel_store) begin
                mem_addr      <= head.addr;
                mem_wdata     <= head.wdata;
                mem_sign_mask <= head.sign_mask;
                op_load       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data_mem model that
// logs every request it sees, in order.
module tb_store_buffer;
    import sail_mem_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_memwrite = 1'b0;
    logic        cpu_memread = 1'b0;
    logic [3:0]  cpu_sign_mask = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_memread   (cpu_memread),
        .cpu_sign_mask (cpu_sign_mask),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_sign_mask (mem_sign_mask),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_rdata     (mem_rdata),
        .mem_stall     (mem_stall)
    );

    // ---------------- data_mem model ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } log_t;

    bit [31:0]   mem [4096];
    log_t        log_q [$];
    logic [31:0] rdata_q = '0;
    int unsigned stall_cnt = 0;
    int unsigned extra_wait = 0;
    bit          preloaded = 1'b0;

    assign mem_rdata = rdata_q;
    assign mem_stall = (stall_cnt != 0);

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [3:0] m);
        logic [31:0] s;
        s = w >> (8 * off);
        case (m[2:0])
            3'b001:  s = m[3] ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            3'b011:  s = m[3] ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [3:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (m[2:0])
            3'b001:  r[{off, 3'b000} +: 8] = d[7:0];
            3'b011:  r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (!preloaded) begin
            mem[32'h300 >> 2]  <= 32'h12345678;
            mem[32'h2004 >> 2] <= 32'h0BADF00D;
            preloaded <= 1'b1;
        end
        if (mem_memwrite) begin
            mem[mem_addr[13:2]] <= st_model(mem[mem_addr[13:2]], mem_addr[1:0], mem_sign_mask,
                                            mem_wdata);
            log_q.push_back('{wr: 1'b1, addr: mem_addr, data: mem_wdata});
        end
        if (mem_memread) begin
            rdata_q <= ld_model(mem[mem_addr[13:2]], mem_addr[1:0], mem_sign_mask);
            log_q.push_back('{wr: 1'b0, addr: mem_addr, data: 32'h0});
        end
        if (mem_memwrite || mem_memread) begin
            stall_cnt <= extra_wait;
        end else if (stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (!(cpu_memread && cpu_memwrite)) else $error("illegal read+write");
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one access from #1 after an edge; returns #1 after the edge that takes it.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, output int stalls, output logic [31:0] rd);
        bit done;
        done = 1'b0;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_sign_mask = m;
        cpu_memwrite = wr;
        cpu_memread = ~wr;
        stalls = 0;
        rd = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        rd = cpu_rdata;
        check("access completes", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        cpu_memwrite = 1'b0;
        cpu_memread = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        int          base;
        bit          ok;
        logic [31:0] exp_a [5];

        vecs[0] = '{1'b1, 32'h10,  32'h11223344, SM_WORD,  32'h0,        0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        SM_WORD,  32'h11223344, 3};
        vecs[2] = '{1'b1, 32'h13,  32'h000000AB, SM_BYTE,  32'h0,        0};
        vecs[3] = '{1'b0, 32'h13,  32'h0,        SM_BYTEU, 32'h000000AB, 3};
        vecs[4] = '{1'b0, 32'h13,  32'h0,        SM_BYTE,  32'hFFFFFFAB, 3};
        vecs[5] = '{1'b0, 32'h12,  32'h0,        SM_HALF,  32'hFFFFAB22, 3};
        vecs[6] = '{1'b0, 32'h10,  32'h0,        SM_HALFU, 32'h00003344, 3};
        vecs[7] = '{1'b1, 32'h16,  32'h0000BEEF, SM_HALF,  32'h0,        0};
        vecs[8] = '{1'b0, 32'h14,  32'h0,        SM_WORD,  32'hBEEF0000, 3};
        vecs[9] = '{1'b0, 32'h300, 32'h0,        SM_WORD,  32'h12345678, 3};

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset cpu_stall", 32'(cpu_stall), 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
        check("reset count", 32'(dut.count), 32'h0);
        @(posedge clk);
        #1;

        // Table of isolated accesses, each started with the queue drained and FSM idle
        for (int i = 0; i < 10; i++) begin
            cycles(6);
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, st, rd);
            check($sformatf("vec%0d stall cycles", i), 32'(st), 32'(vecs[i].exp_stall));
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        end

        // Single store drain timing
        cycles(6);
        do_access(1'b1, 32'h100, 32'hDEADBEEF, SM_WORD, st, rd);
        check("t1 store stall", 32'(st), 32'h0);
        @(negedge clk);
        check("t1 c1 memwrite", 32'(mem_memwrite), 32'h0);
        check("t1 c1 count", 32'(dut.count), 32'h1);
        @(negedge clk);
        check("t1 c2 memwrite", 32'(mem_memwrite), 32'h1);
        check("t1 c2 mem_addr", mem_addr, 32'h100);
        check("t1 c2 mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("t1 c3 memwrite", 32'(mem_memwrite), 32'h0);
        @(negedge clk);
        check("t1 c4 count", 32'(dut.count), 32'h0);
        @(posedge clk);
        #1;

        // Five back-to-back stores into a slow memory: the fifth must stall
        extra_wait = 4;
        cycles(6);
        base = log_q.size();
        for (int i = 0; i < 5; i++) begin
            do_access(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), SM_WORD, st, rd);
            if (i < 4) check($sformatf("t2 store%0d stall", i), 32'(st), 32'h0);
            else       check("t2 store4 stalled", 32'(st > 0), 32'h1);
        end
        check("t2 count after full accept", 32'(dut.count), 32'(DEPTH));
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (log_q.size() >= base + 5) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
        check("t2 all stores drained", 32'(ok), 32'h1);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2 order%0d addr", i), log_q[base + i].addr, 32'(4 * i));
                check($sformatf("t2 order%0d data", i), log_q[base + i].data,
                      32'hA000_0000 + 32'(i));
            end
        end
        extra_wait = 0;

        // Non-hazard load overtakes a queued store
        cycles(10);
        base = log_q.size();
        do_access(1'b1, 32'h200, 32'h1, SM_WORD, st, rd);
        do_access(1'b1, 32'h204, 32'h2, SM_WORD, st, rd);
        do_access(1'b0, 32'h300, 32'h0, SM_WORD, st, rd);
        check("t3 rdata", rd, 32'h12345678);
        cycles(10);
        check("t3 log length", 32'(log_q.size() >= base + 3), 32'h1);
        if (log_q.size() >= base + 3) begin
            exp_a[0] = 32'h200;
            exp_a[1] = 32'h300;
            exp_a[2] = 32'h204;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t3 req%0d addr", i), log_q[base + i].addr, exp_a[i]);
                check($sformatf("t3 req%0d op", i), 32'(log_q[base + i].wr),
                      32'(i != 1));
            end
        end

        // Word-address hazard: load waits for the matching store
        cycles(6);
        base = log_q.size();
        do_access(1'b1, 32'h40, 32'hA5A5A5A5, SM_WORD, st, rd);
        do_access(1'b0, 32'h42, 32'h0, SM_HALF, st, rd);
        check("t4 rdata", rd, 32'hFFFFA5A5);
        check("t4 stall cycles", 32'(st), 32'd6);
        check("t4 log length", 32'(log_q.size() >= base + 2), 32'h1);
        if (log_q.size() >= base + 2) begin
            check("t4 first is store", 32'(log_q[base].wr), 32'h1);
            check("t4 second addr", log_q[base + 1].addr, 32'h42);
        end

        // MMIO load to a different word still waits for the queue to empty
        cycles(6);
        base = log_q.size();
        do_access(1'b1, 32'h2000, 32'hCAFE0001, SM_WORD, st, rd);
        do_access(1'b0, 32'h2004, 32'h0, SM_WORD, st, rd);
        check("t5 rdata", rd, 32'h0BADF00D);
        check("t5 stall cycles", 32'(st), 32'd6);
        check("t5 log length", 32'(log_q.size() >= base + 2), 32'h1);
        if (log_q.size() >= base + 2) begin
            check("t5 first is store", 32'(log_q[base].wr), 32'h1);
            check("t5 second addr", log_q[base + 1].addr, 32'h2004);
        end

        // Reset during M_WAIT with three stores queued
        extra_wait = 6;
        cycles(6);
        base = log_q.size();
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 32'h500 + 32'(4 * i), 32'h5 + 32'(i), SM_WORD, st, rd);
        end
        check("t6 count before reset", 32'(dut.count), 32'h3);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 count", 32'(dut.count), 32'h0);
        check("t6 memwrite", 32'(mem_memwrite), 32'h0);
        check("t6 cpu_stall", 32'(cpu_stall), 32'h0);
        check("t6 mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra_wait = 0;
        cycles(20);
        check("t6 no writes after reset", 32'(log_q.size()), 32'(base + 1));
        do_access(1'b0, 32'h100, 32'h0, SM_WORD, st, rd);
        check("t6 load after reset", rd, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
